// File: rtl/arm_pkg.sv
// Shared types for the arm motion sequencer: state codes, default home pose and
// channel slicing helper for the packed N_CH*DW buses.
`ifndef ARM_PKG_SV
`define ARM_PKG_SV

`define ARM_CH(bus, i, dw) bus[(i)*(dw) +: (dw)]

package arm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LIVE     = 3'd1,
    ST_PB_FETCH = 3'd2,
    ST_PB_HOLD  = 3'd3,
    ST_RETURN   = 3'd4
  } state_t;

  localparam int HOME_DEFAULT = 50;

endpackage

`endif

// File: rtl/arm_slew_limiter.sv
// One joint channel: on each tick moves out toward target by at most SLEW.
// Latency: 1 clk from tick to updated out; never overshoots or wraps.
module arm_slew_limiter
  import arm_pkg::*;
#(
  parameter int DW   = 8,
  parameter int SLEW = 4,
  parameter int HOME = HOME_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic [DW-1:0] i_target,
  output logic [DW-1:0] o_out
);

  localparam logic signed [DW:0] SLEW_S = (DW+1)'(SLEW);

  logic [DW-1:0]        r_out;
  logic signed [DW:0]   w_diff;
  logic [DW-1:0]        w_next;

  assign w_diff = $signed({1'b0, i_target}) - $signed({1'b0, r_out});

  // Within the slew window the step lands exactly on target.
  always_comb begin
    w_next = i_target;
    if (w_diff > SLEW_S) begin
      w_next = r_out + DW'(SLEW);
    end else if (w_diff < -SLEW_S) begin
      w_next = r_out - DW'(SLEW);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out <= DW'(HOME);
    end else if (i_tick) begin
      r_out <= w_next;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/arm_motion_sequencer.sv
// Mode FSM selecting home / live / ROM-playback setpoints, with tick, step and ROM
// address counters and N_CH slew-limited output channels.
module arm_motion_sequencer
  import arm_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int DW       = 8,
  parameter int AW       = 6,
  parameter int PB_LEN   = 64,
  parameter int HOME     = HOME_DEFAULT,
  parameter int TICK_DIV = 50000,
  parameter int STEP_TK  = 10,
  parameter int SLEW     = 4,
  parameter int LOOP     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_btn_mem,
  input  logic [N_CH*DW-1:0] i_accel_data,
  input  logic               i_accel_valid,
  output logic [AW-1:0]      o_rom_addr,
  input  logic [N_CH*DW-1:0] i_rom_data,
  output logic [N_CH*DW-1:0] o_data_out,
  output logic               o_out_valid,
  output logic [2:0]         o_state,
  output logic               o_at_home
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STEP_TK) + 1;
  localparam logic [N_CH*DW-1:0] HOME_VEC = {N_CH{DW'(HOME)}};

  state_t              r_state;
  logic [TW-1:0]       r_tick_cnt;
  logic [SW-1:0]       r_step_cnt;
  logic [AW-1:0]       r_rom_addr;
  logic                r_fetch_ph;
  logic                r_out_valid;
  logic [N_CH*DW-1:0]  r_target;
  logic                w_tick;
  logic                w_at_home;
  logic                w_last_word;

  assign w_tick      = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_last_word = !({1'b0, r_rom_addr} < (AW+1)'(PB_LEN - 1));

  always_comb begin
    w_at_home = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (`ARM_CH(o_data_out, i, DW) != DW'(HOME)) w_at_home = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_step_cnt  <= '0;
      r_rom_addr  <= '0;
      r_fetch_ph  <= 1'b0;
      r_out_valid <= 1'b0;
      r_target    <= HOME_VEC;
    end else begin
      r_out_valid <= w_tick;
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_target <= HOME_VEC;
          if (i_enable) begin
            if (i_btn_mem) begin
              r_state    <= ST_PB_FETCH;
              r_rom_addr <= '0;
              r_fetch_ph <= 1'b0;
            end else begin
              r_state <= ST_LIVE;
            end
          end
        end

        ST_LIVE: begin
          if (!i_enable) begin
            r_state  <= ST_RETURN;
            r_target <= HOME_VEC;
          end else if (i_accel_valid) begin
            r_target <= i_accel_data;
          end
        end

        // Phase 0 presents the address; the synchronous ROM answers in phase 1.
        ST_PB_FETCH: begin
          if (!i_enable) begin
            r_state  <= ST_RETURN;
            r_target <= HOME_VEC;
          end else if (!r_fetch_ph) begin
            r_fetch_ph <= 1'b1;
          end else begin
            r_target   <= i_rom_data;
            r_step_cnt <= '0;
            r_state    <= ST_PB_HOLD;
          end
        end

        ST_PB_HOLD: begin
          if (!i_enable) begin
            r_state  <= ST_RETURN;
            r_target <= HOME_VEC;
          end else if (w_tick) begin
            if (r_step_cnt == SW'(STEP_TK - 1)) begin
              r_step_cnt <= '0;
              if (!w_last_word) begin
                r_rom_addr <= r_rom_addr + 1'b1;
                r_fetch_ph <= 1'b0;
                r_state    <= ST_PB_FETCH;
              end else if (LOOP != 0) begin
                r_rom_addr <= '0;
                r_fetch_ph <= 1'b0;
                r_state    <= ST_PB_FETCH;
              end else begin
                r_target <= HOME_VEC;
                r_state  <= ST_RETURN;
              end
            end else begin
              r_step_cnt <= r_step_cnt + 1'b1;
            end
          end
        end

        ST_RETURN: begin
          r_target <= HOME_VEC;
          if (w_at_home) r_state <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_target <= HOME_VEC;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    arm_slew_limiter #(
      .DW   (DW),
      .SLEW (SLEW),
      .HOME (HOME)
    ) u_slew (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_tick   (w_tick),
      .i_target (`ARM_CH(r_target, g, DW)),
      .o_out    (`ARM_CH(o_data_out, g, DW))
    );
  end

  assign o_rom_addr  = r_rom_addr;
  assign o_out_valid = r_out_valid;
  assign o_state     = r_state;
  assign o_at_home   = w_at_home;

endmodule

// File: tb/tb_arm_motion_sequencer.sv
// Directed bench: one non-looping and one looping sequencer share stimulus; each
// has its own synchronous ROM model holding {60,70,80} replicated on all channels.
module tb_arm_motion_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        btn = 1'b0;
  logic [23:0] accel_data = '0;
  logic        accel_valid = 1'b0;
  logic [5:0]  rom_addr0, rom_addr1;
  logic [23:0] rom_data0 = '0, rom_data1 = '0;
  logic [23:0] data0, data1;
  logic        valid0, valid1;
  logic [2:0]  st0, st1;
  logic        home0, home1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [5:0] a);
    case (a)
      6'd0:    return 8'd60;
      6'd1:    return 8'd70;
      6'd2:    return 8'd80;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    rom_data0 <= {3{rom_byte(rom_addr0)}};
    rom_data1 <= {3{rom_byte(rom_addr1)}};
  end

  arm_motion_sequencer #(
    .N_CH(3), .DW(8), .AW(6), .PB_LEN(3), .HOME(50),
    .TICK_DIV(4), .STEP_TK(2), .SLEW(4), .LOOP(0)
  ) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_enable(enable), .i_btn_mem(btn),
    .i_accel_data(accel_data), .i_accel_valid(accel_valid),
    .o_rom_addr(rom_addr0), .i_rom_data(rom_data0),
    .o_data_out(data0), .o_out_valid(valid0), .o_state(st0), .o_at_home(home0)
  );

  arm_motion_sequencer #(
    .N_CH(3), .DW(8), .AW(6), .PB_LEN(3), .HOME(50),
    .TICK_DIV(4), .STEP_TK(2), .SLEW(4), .LOOP(1)
  ) u_dut_loop (
    .i_clk(clk), .i_rst(rst_n), .i_enable(enable), .i_btn_mem(btn),
    .i_accel_data(accel_data), .i_accel_valid(accel_valid),
    .o_rom_addr(rom_addr1), .i_rom_data(rom_data1),
    .o_data_out(data1), .o_out_valid(valid1), .o_state(st1), .o_at_home(home1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int ch(input logic [23:0] v, input int i);
    return int'(v[i*8 +: 8]);
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic wait_valid(input string tag);
    int ok = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (valid0) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_st(input int which, input int want, input int bound, input string tag);
    int ok = 0;
    for (int c = 0; c < bound; c++) begin
      if ((which == 0 ? int'(st0) : int'(st1)) == want) begin
        ok = 1;
        break;
      end
      step(1);
    end
    chk(tag, ok, 1);
  endtask

  task automatic load_accel(input logic [23:0] v);
    accel_data  = v;
    accel_valid = 1'b1;
    step(1);
    accel_valid = 1'b0;
  endtask

  initial begin
    int q0[$];
    int q1[$];
    int hl[$];
    int p0, p1, hc, exp_v, found;

    // Reset state
    step(2);
    chk("rst_state", st0, 0);
    chk("rst_ch0", ch(data0, 0), 50);
    chk("rst_ch2", ch(data0, 2), 50);
    chk("rst_at_home", home0, 1);
    chk("rst_rom_addr", rom_addr0, 0);
    chk("rst_valid", valid0, 0);
    rst_n = 1'b1;
    step(1);

    // LIVE tracking
    enable = 1'b1;
    btn    = 1'b0;
    step(1);
    chk("live_enter", st0, 1);
    load_accel({8'd38, 8'd50, 8'd62});
    wait_valid("live_t1_to");
    chk("live_t1_ch0", ch(data0, 0), 54);
    chk("live_t1_ch1", ch(data0, 1), 50);
    chk("live_t1_ch2", ch(data0, 2), 46);
    wait_valid("live_t2_to");
    chk("live_t2_ch0", ch(data0, 0), 58);
    chk("live_t2_ch2", ch(data0, 2), 42);
    wait_valid("live_t3_to");
    chk("live_t3_ch0", ch(data0, 0), 62);
    chk("live_t3_ch2", ch(data0, 2), 38);
    wait_valid("live_t4_to");
    chk("live_hold_ch0", ch(data0, 0), 62);
    chk("live_hold_ch2", ch(data0, 2), 38);
    chk("live_not_home", home0, 0);

    // Extremes: settle at 0, then ramp to 255 in +4 steps
    load_accel(24'd0);
    for (int t = 0; t < 16; t++) wait_valid("ext_down_to");
    chk("ext_zero_ch0", ch(data0, 0), 0);
    chk("ext_zero_ch1", ch(data0, 1), 0);
    chk("ext_zero_ch2", ch(data0, 2), 0);
    load_accel({8'd0, 8'd0, 8'd255});
    exp_v = 0;
    for (int t = 0; t < 64; t++) begin
      wait_valid("ext_up_to");
      exp_v = (exp_v + 4 > 255) ? 255 : exp_v + 4;
      chk("ext_ramp_ch0", ch(data0, 0), exp_v);
    end
    wait_valid("ext_hold_to");
    chk("ext_final_ch0", ch(data0, 0), 255);
    chk("ext_final_ch1", ch(data0, 1), 0);

    // btn_mem ignored outside IDLE
    btn = 1'b1;
    step(3);
    chk("btn_in_live", st0, 1);
    btn = 1'b0;
    step(1);

    enable = 1'b0;
    step(1);
    chk("live_to_return", st0, 4);
    wait_st(0, 0, 400, "live_return_idle_to");
    chk("live_ret_ch0", ch(data0, 0), 50);
    chk("live_ret_home", home0, 1);
    step(1);

    // Playback: LOOP=0 and LOOP=1 side by side
    enable = 1'b1;
    btn    = 1'b1;
    p0 = 0; p1 = 0; hc = 0; found = 0;
    for (int c = 0; c < 300; c++) begin
      step(1);
      if (st0 == 3'd2 && p0 != 2) q0.push_back(int'(rom_addr0));
      if (st1 == 3'd2 && p1 != 2) q1.push_back(int'(rom_addr1));
      if (st0 == 3'd3) hc++;
      else if (p0 == 3) begin
        hl.push_back(hc);
        hc = 0;
      end
      p0 = int'(st0);
      p1 = int'(st1);
      if (st0 == 3'd4) begin
        found = 1;
        break;
      end
    end
    chk("pb_return_to", found, 1);
    chk("pb_addr_cnt", q0.size(), 3);
    chk("pb_addr0", qget(q0, 0), 0);
    chk("pb_addr1", qget(q0, 1), 1);
    chk("pb_addr2", qget(q0, 2), 2);
    chk("pb_hold_w1", qget(hl, 1), 6);
    chk("pb_hold_w2", qget(hl, 2), 6);
    chk("pb_ret_addr", rom_addr0, 2);
    chk("pb_ret_ch0", ch(data0, 0), 74);
    chk("pb_ret_ch1", ch(data0, 1), 74);
    chk("loop_seq_cnt", q1.size(), 4);
    chk("loop_seq2", qget(q1, 2), 2);
    chk("loop_seq3", qget(q1, 3), 0);
    chk("loop_state", st1, 2);
    chk("loop_addr", rom_addr1, 0);

    enable = 1'b0;
    btn    = 1'b0;
    wait_st(0, 0, 200, "pb_idle_to");
    chk("pb_idle_ch0", ch(data0, 0), 50);
    chk("pb_idle_home", home0, 1);
    wait_st(1, 0, 200, "loop_idle_to");

    // Enable drop on the step tick: RETURN wins, address frozen
    enable = 1'b1;
    btn    = 1'b1;
    found  = 0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (st0 == 3'd3 && valid0 && ch(data0, 0) == 54) begin
        found = 1;
        break;
      end
    end
    chk("drop_first_tick_to", found, 1);
    step(3);
    enable = 1'b0;
    btn    = 1'b0;
    step(1);
    chk("drop_state", st0, 4);
    chk("drop_addr", rom_addr0, 0);
    chk("drop_valid", valid0, 1);
    chk("drop_ch0", ch(data0, 0), 58);
    wait_st(0, 0, 100, "drop_idle_to");

    // Asynchronous reset mid-motion
    enable = 1'b1;
    step(1);
    load_accel({8'd80, 8'd80, 8'd80});
    for (int t = 0; t < 8; t++) wait_valid("rst80_to");
    chk("pre_rst_ch0", ch(data0, 0), 80);
    rst_n = 1'b0;
    #1;
    chk("arst_ch0", ch(data0, 0), 50);
    chk("arst_ch1", ch(data0, 1), 50);
    chk("arst_ch2", ch(data0, 2), 50);
    chk("arst_state", st0, 0);
    chk("arst_home", home0, 1);
    chk("arst_valid", valid0, 0);
    enable = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
